// File: rtl/uart_loopback_fifo_pkg.sv
// Shared types, frame-format constants and byte helpers for the UART loopback.
// The transform and parity helpers operate on a zero-extended 8-bit view of the data.
package uart_loopback_fifo_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [1:0] {
    MODE_ECHO = 2'd0,
    MODE_CASE = 2'd1,
    MODE_INV  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_LOAD   = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5
  } tx_state_e;

  // Case swap only makes sense for full ASCII bytes; narrower frames pass through.
  function automatic logic [7:0] transform(input logic [7:0] d, input mode_e m, input int data_bits);
    logic [7:0] r;
    r = d;
    case (m)
      MODE_CASE: begin
        if (data_bits == 8) begin
          if (d >= 8'h61 && d <= 8'h7A)      r = d - 8'h20;
          else if (d >= 8'h41 && d <= 8'h5A) r = d + 8'h20;
        end
      end
      MODE_INV: r = ~d;
      default:  r = d;
    endcase
    return r;
  endfunction

  function automatic logic parity_bit(input logic [7:0] d, input int parity);
    return (parity == PARITY_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_loopback_fifo_if.sv
// Pin-level bundle of the UART loopback: serial lines, mode/status controls.
// slave is the design side, master the board/bench side.
interface uart_loopback_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic          uart_rxd;
  logic          uart_txd;
  logic [1:0]    mode;
  logic          err_clr;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic          frame_err;
  logic          parity_err;

  modport slave (
    input  uart_rxd, mode, err_clr,
    output uart_txd, fifo_level, overflow, frame_err, parity_err
  );

  modport master (
    output uart_rxd, mode, err_clr,
    input  uart_txd, fifo_level, overflow, frame_err, parity_err
  );
endinterface

// File: rtl/uart_loopback_fifo_sync_fifo.sv
// Synchronous FIFO with registered read data and a separate occupancy counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q;
  logic [DATA_W-1:0] rdata_q;
  logic              push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = rdata_q;
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem_q[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_loopback_fifo.sv
// UART loopback: RX deserialiser with parity/framing checks, buffering FIFO,
// per-byte transform selected at pop time, and TX serialiser.
module uart_loopback_fifo
  import uart_loopback_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  uart_loopback_fifo_if.slave  bus
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(STOP_BITS * BPS_CNT + 1);
  localparam int BW      = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_MID   = CW'(BPS_CNT / 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * BPS_CNT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  // RX
  logic [1:0]           rx_sync_q;
  logic                 rx_prev_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_s, rx_fall, rx_mid, rx_end;
  logic                 rx_push, rx_ferr, rx_perr;

  // FIFO
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic [AW:0]          fifo_level;

  // TX
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_txd_q, tx_txd_d;
  mode_e                tx_mode_q, tx_mode_d;
  logic                 tx_pop, tx_end, tx_stop_end;
  logic [7:0]           tx_byte;
  mode_e                mode_in;

  logic                 overflow_q;

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;
  assign rx_mid  = (rx_cnt_q == CNT_MID);
  assign rx_end  = (rx_cnt_q == CNT_LAST);
  assign mode_in = mode_e'(bus.mode);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_ferr    = 1'b0;
    rx_perr    = 1'b0;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_mid && rx_s) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
        end else if (rx_end) begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (rx_mid) rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
        if (rx_end) begin
          rx_cnt_d = '0;
          if (rx_bit_q == BIT_LAST) rx_state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_mid) rx_par_d = rx_s;
        if (rx_end) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (rx_mid) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
          rx_ferr    = !rx_s;
          rx_perr    = (PARITY != PARITY_NONE) && (rx_par_q != parity_bit(8'(rx_shift_q), PARITY));
          rx_push    = !rx_ferr && !rx_perr;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], bus.uart_rxd};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .push_i  (rx_push),
    .pop_i   (tx_pop),
    .wdata_i (rx_shift_q),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tx_end      = (tx_cnt_q == CNT_LAST);
  assign tx_stop_end = (tx_cnt_q == STOP_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_txd_d   = tx_txd_q;
    tx_mode_d  = tx_mode_q;
    tx_pop     = 1'b0;
    tx_byte    = '0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_txd_d = 1'b1;
        if (!fifo_empty && mode_in != MODE_HOLD) begin
          tx_pop     = 1'b1;
          tx_mode_d  = mode_in;
          tx_state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        tx_byte    = transform(8'(fifo_rdata), tx_mode_q, DATA_BITS);
        tx_shift_d = DATA_BITS'(tx_byte);
        tx_par_d   = parity_bit(8'(tx_shift_d), PARITY);
        tx_txd_d   = 1'b0;
        tx_cnt_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: begin
        if (tx_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_txd_d   = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
            tx_txd_d   = (PARITY != PARITY_NONE) ? tx_par_q : 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_txd_d   = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_end) begin
          tx_cnt_d   = '0;
          tx_txd_d   = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_stop_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_txd_q   <= 1'b1;
      tx_mode_q  <= MODE_ECHO;
      overflow_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_txd_q   <= tx_txd_d;
      tx_mode_q  <= tx_mode_d;
      // A drop in the same cycle as a clear must remain visible.
      if (rx_push && fifo_full && !tx_pop) overflow_q <= 1'b1;
      else if (bus.err_clr)                overflow_q <= 1'b0;
    end
  end

  assign bus.uart_txd   = tx_txd_q;
  assign bus.fifo_level = fifo_level;
  assign bus.overflow   = overflow_q;
  assign bus.frame_err  = rx_ferr;
  assign bus.parity_err = rx_perr;

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Directed bench: even parity, 4-deep FIFO, 16 clocks per bit; TX frames are decoded
// by a line monitor and compared against hand-computed bytes.
module tb_uart_loopback_fifo;

  localparam int BPS = 16;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   fe_cnt = 0;
  int   pe_cnt = 0;
  bit   lvl_nz = 1'b0;
  logic [10:0] mon_q [$];

  uart_loopback_fifo_if #(.FIFO_DEPTH(4)) bus ();

  uart_loopback_fifo #(
    .CLK_FREQ   (1600000),
    .UART_BPS   (100000),
    .DATA_BITS  (8),
    .PARITY     (2),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1)  fe_cnt++;
    if (bus.parity_err === 1'b1) pe_cnt++;
    if (bus.fifo_level != 0)     lvl_nz = 1'b1;
  end

  // TX line decoder: records {stop, parity, data} per frame
  initial begin : tx_mon
    logic [10:0] w;
    forever begin
      @(negedge clk);
      if (bus.uart_txd === 1'b0) begin
        repeat (BPS/2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          repeat (BPS) @(negedge clk);
          w[i] = bus.uart_txd;
        end
        mon_q.push_back(w);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    bus.uart_rxd = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = d[i];
      repeat (BPS) @(negedge clk);
    end
    bus.uart_rxd = (^d) ^ bad_par;
    repeat (BPS) @(negedge clk);
    bus.uart_rxd = !bad_stop;
    repeat (BPS) @(negedge clk);
    bus.uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d);
    int n;
    n = 0;
    while (mon_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (mon_q.size() == 0) check({tag, "_timeout"}, mon_q.size(), 1);
    else                   check(tag, 32'(mon_q.pop_front()), {21'd0, 1'b1, ^d, d});
  endtask

  initial begin : main
    int n;
    bus.uart_rxd = 1'b1;
    bus.mode     = 2'd0;
    bus.err_clr  = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_txd",   bus.uart_txd,   1);
    check("rst_level", bus.fifo_level, 0);
    check("rst_ovf",   bus.overflow,   0);
    check("rst_ferr",  bus.frame_err,  0);
    check("rst_perr",  bus.parity_err, 0);
    sys_rst = 1'b0;
    @(negedge clk);

    // echo with push-to-start latency
    fork
      send_frame(8'h55, 1'b0, 1'b0);
    join_none
    n = 0;
    while (bus.fifo_level != 1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t1_push_seen", bus.fifo_level, 1);
    @(negedge clk);
    check("t1_txd_lat1", bus.uart_txd, 1);
    @(negedge clk);
    check("t1_txd_lat2", bus.uart_txd, 0);
    expect_frame("t1_echo", 8'h55);
    check("t1_ferr_cnt", fe_cnt, 0);
    check("t1_perr_cnt", pe_cnt, 0);

    // case swap
    bus.mode = 2'd1;
    send_frame(8'h61, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h31, 1'b0, 1'b0);
    expect_frame("t2_lower_a", 8'h41);
    expect_frame("t2_upper_z", 8'h7A);
    expect_frame("t2_digit",   8'h31);

    // parity error discards the byte
    bus.mode = 2'd0;
    fe_cnt = 0; pe_cnt = 0; lvl_nz = 1'b0;
    send_frame(8'hA3, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    check("t3_perr_cnt", pe_cnt, 1);
    check("t3_ferr_cnt", fe_cnt, 0);
    check("t3_level_nz", lvl_nz, 0);
    check("t3_no_tx",    mon_q.size(), 0);

    // hold mode fills the FIFO and overflows
    bus.mode = 2'd3;
    for (int i = 0; i < 6; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
    check("t4_level_full", bus.fifo_level, 4);
    check("t4_ovf_set",    bus.overflow,   1);
    check("t4_hold_no_tx", mon_q.size(),   0);
    bus.mode = 2'd0;
    expect_frame("t4_b0", 8'h10);
    expect_frame("t4_b1", 8'h11);
    expect_frame("t4_b2", 8'h12);
    expect_frame("t4_b3", 8'h13);
    repeat (300) @(negedge clk);
    check("t4_no_extra", mon_q.size(),   0);
    check("t4_level_0",  bus.fifo_level, 0);
    check("t4_ovf_kept", bus.overflow,   1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("t4_ovf_clr",  bus.overflow,   0);

    // framing error, then recovery and invert mode
    fe_cnt = 0; pe_cnt = 0; lvl_nz = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("t5_ferr_cnt", fe_cnt, 1);
    check("t5_perr_cnt", pe_cnt, 0);
    check("t5_level_nz", lvl_nz, 0);
    send_frame(8'hC3, 1'b0, 1'b0);
    expect_frame("t5_recover", 8'hC3);
    bus.mode = 2'd2;
    send_frame(8'h0F, 1'b0, 1'b0);
    expect_frame("t5_invert", 8'hF0);
    bus.mode = 2'd0;
    repeat (40) @(negedge clk);

    // reset mid data bit with a byte still queued
    bus.mode = 2'd3;
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b0);
    check("t6_level_2", bus.fifo_level, 2);
    bus.mode = 2'd0;
    n = 0;
    while (bus.uart_txd !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_start_seen", bus.uart_txd, 0);
    repeat (BPS + BPS/2) @(negedge clk);
    check("t6_bit0_low", bus.uart_txd,   0);
    check("t6_level_1",  bus.fifo_level, 1);
    sys_rst = 1'b1;
    @(negedge clk);
    check("t6_rst_txd",   bus.uart_txd,   1);
    check("t6_rst_level", bus.fifo_level, 0);
    check("t6_rst_ovf",   bus.overflow,   0);
    check("t6_rst_ferr",  bus.frame_err,  0);
    check("t6_rst_perr",  bus.parity_err, 0);
    sys_rst = 1'b0;
    repeat (300) @(negedge clk);
    mon_q.delete();
    check("t6_level_after", bus.fifo_level, 0);

    // single-cycle glitch on rxd
    fe_cnt = 0; pe_cnt = 0; lvl_nz = 1'b0;
    bus.uart_rxd = 1'b0;
    @(negedge clk);
    bus.uart_rxd = 1'b1;
    repeat (300) @(negedge clk);
    check("t6_glitch_level", lvl_nz, 0);
    check("t6_glitch_ferr",  fe_cnt, 0);
    check("t6_glitch_perr",  pe_cnt, 0);
    check("t6_glitch_no_tx", mon_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
